bcmp_sched: RTL and testbench

- Shares the single branch comparator datapath between two requesters:
  - Requester 0: the branch unit (BEQ/BNE/BLT/BGE/BLTU/BGEU).
  - Requester 1: the ALU set-less-than path (SLT/SLTU).
- Round-robin arbitration, valid/ready request handshakes, one registered response slot.
- Branch-taken decode from funct3.
- Sits between decode/execute and the comparator in the execute stage.

---
 rtl/bcmp_sched_pkg.sv | 39 +++
 rtl/bcmp_sched_if.sv | 39 +++
 rtl/bcmp_sched_core.sv | 22 ++
 rtl/bcmp_sched.sv | 121 ++++++++++++
 tb/tb_bcmp_sched.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcmp_sched_pkg.sv
// Shared constants, result payload and funct3 decode helpers for the branch comparator scheduler.
package bcmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic REQ_BR  = 1'b0;
  localparam logic REQ_SLT = 1'b1;

  typedef struct packed {
    logic taken;
    logic eq;
    logic lt;
    logic illegal;
  } br_rsp_t;

  // 010/011 are not branch encodings: never taken, flagged illegal.
  function automatic logic br_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/bcmp_sched_if.sv
// Request/response handshake bundle between the two requesters and bcmp_sched.
interface bcmp_sched_if #(parameter int unsigned XLEN = 32);

  logic            r0_valid;
  logic            r0_ready;
  logic [XLEN-1:0] r0_op1;
  logic [XLEN-1:0] r0_op2;
  logic [2:0]      r0_funct3;
  logic            r0_rsp_valid;
  logic            r0_rsp_ready;
  logic            r0_taken;
  logic            r0_eq;
  logic            r0_lt;
  logic            r0_illegal;

  logic            r1_valid;
  logic            r1_ready;
  logic [XLEN-1:0] r1_op1;
  logic [XLEN-1:0] r1_op2;
  logic            r1_unsigned;
  logic            r1_rsp_valid;
  logic            r1_rsp_ready;
  logic            r1_lt;

  modport master (
    output r0_valid, r0_op1, r0_op2, r0_funct3, r0_rsp_ready,
    output r1_valid, r1_op1, r1_op2, r1_unsigned, r1_rsp_ready,
    input  r0_ready, r0_rsp_valid, r0_taken, r0_eq, r0_lt, r0_illegal,
    input  r1_ready, r1_rsp_valid, r1_lt
  );

  modport slave (
    input  r0_valid, r0_op1, r0_op2, r0_funct3, r0_rsp_ready,
    input  r1_valid, r1_op1, r1_op2, r1_unsigned, r1_rsp_ready,
    output r0_ready, r0_rsp_valid, r0_taken, r0_eq, r0_lt, r0_illegal,
    output r1_ready, r1_rsp_valid, r1_lt
  );

endinterface

// File: rtl/bcmp_sched_core.sv
// Combinational comparator: equality plus signed/unsigned less-than.
module bcmp_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            uns,
  output logic            eq,
  output logic            lt
);

  logic ult;
  logic sign_differs;

  assign eq           = (op1 == op2);
  assign ult          = (op1 < op2);
  assign sign_differs = (op1[XLEN-1] != op2[XLEN-1]);

  // With differing signs the negative operand is the smaller one.
  assign lt = (!uns && sign_differs) ? op1[XLEN-1] : ult;

endmodule

// File: rtl/bcmp_sched.sv
// Round-robin share of one branch comparator between the branch unit (r0) and SLT/SLTU (r1).
// Optional perf counters enabled by defining BCMP_SCHED_PERF_EN.
module bcmp_sched
  import bcmp_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  bcmp_sched_if.slave  bus
`ifdef BCMP_SCHED_PERF_EN
  ,
  output logic [31:0]  perf_r0_cnt,
  output logic [31:0]  perf_r1_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  logic            busy;
  logic            owner;
  logic            rr_last;
  logic            r0_rsp_valid_q;
  logic            r1_rsp_valid_q;
  br_rsp_t         br_q;
  logic            slt_lt_q;

  logic            grant0;
  logic            grant1;
  logic            drain;
  logic            can_accept;
  logic            acc0;
  logic            acc1;
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;
  logic            cmp_uns;
  logic            cmp_eq;
  logic            cmp_lt;

  // Grant, slot availability and comparator operand steering.
  always_comb begin
    grant0     = bus.r0_valid & (~bus.r1_valid | (rr_last == REQ_SLT));
    grant1     = bus.r1_valid & (~bus.r0_valid | (rr_last == REQ_BR));
    drain      = (owner == REQ_SLT) ? (r1_rsp_valid_q & bus.r1_rsp_ready)
                                    : (r0_rsp_valid_q & bus.r0_rsp_ready);
    can_accept = ~busy | drain;
    acc0       = grant0 & can_accept;
    acc1       = grant1 & can_accept;
    cmp_a      = grant1 ? bus.r1_op1      : bus.r0_op1;
    cmp_b      = grant1 ? bus.r1_op2      : bus.r0_op2;
    cmp_uns    = grant1 ? bus.r1_unsigned : bus.r0_funct3[1];
  end

  bcmp_core #(.XLEN(XLEN)) u_core (
    .op1 (cmp_a),
    .op2 (cmp_b),
    .uns (cmp_uns),
    .eq  (cmp_eq),
    .lt  (cmp_lt)
  );

  // Response slot; non-owner result fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= 1'b0;
      owner          <= REQ_BR;
      rr_last        <= REQ_SLT;
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      br_q           <= '0;
      slt_lt_q       <= 1'b0;
    end else if (acc0) begin
      busy           <= 1'b1;
      owner          <= REQ_BR;
      rr_last        <= REQ_BR;
      r0_rsp_valid_q <= 1'b1;
      r1_rsp_valid_q <= 1'b0;
      br_q           <= '{taken:   br_taken(bus.r0_funct3, cmp_eq, cmp_lt),
                          eq:      cmp_eq,
                          lt:      cmp_lt,
                          illegal: br_illegal(bus.r0_funct3)};
    end else if (acc1) begin
      busy           <= 1'b1;
      owner          <= REQ_SLT;
      rr_last        <= REQ_SLT;
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b1;
      slt_lt_q       <= cmp_lt;
    end else if (drain) begin
      busy           <= 1'b0;
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
    end
  end

  assign bus.r0_ready     = acc0;
  assign bus.r1_ready     = acc1;
  assign bus.r0_rsp_valid = r0_rsp_valid_q;
  assign bus.r1_rsp_valid = r1_rsp_valid_q;
  assign bus.r0_taken     = br_q.taken;
  assign bus.r0_eq        = br_q.eq;
  assign bus.r0_lt        = br_q.lt;
  assign bus.r0_illegal   = br_q.illegal;
  assign bus.r1_lt        = slt_lt_q;

`ifdef BCMP_SCHED_PERF_EN
  // Accept counts per requester and cycles where a request waited.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_r0_cnt    <= '0;
      perf_r1_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (acc0) perf_r0_cnt <= perf_r0_cnt + 32'd1;
      if (acc1) perf_r1_cnt <= perf_r1_cnt + 32'd1;
      if ((bus.r0_valid | bus.r1_valid) & ~(acc0 | acc1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bcmp_sched.sv
// Directed bench for bcmp_sched with a response scoreboard; perf checks need BCMP_SCHED_PERF_EN.
module tb_bcmp_sched;
  import bcmp_pkg::*;

  localparam int unsigned XLEN = 32;

  typedef struct {
    logic who;
    logic taken;
    logic eq;
    logic lt;
    logic ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic acc0;
  logic acc1;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

`ifdef BCMP_SCHED_PERF_EN
  logic [31:0] perf_r0_cnt;
  logic [31:0] perf_r1_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  bcmp_sched_if #(.XLEN(XLEN)) bus ();

  bcmp_sched #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus)
`ifdef BCMP_SCHED_PERF_EN
    ,
    .perf_r0_cnt    (perf_r0_cnt),
    .perf_r1_cnt    (perf_r1_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_r0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    exp_t e;
    e.who = 1'b0;
    e.eq  = (a == b);
    e.lt  = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    e.ill = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:         e.taken = e.eq;
      3'b001:         e.taken = !e.eq;
      3'b100, 3'b110: e.taken = e.lt;
      3'b101, 3'b111: e.taken = !e.lt;
      default:        e.taken = 1'b0;
    endcase
    return e;
  endfunction

  function automatic exp_t model_r1(input logic [31:0] a, input logic [31:0] b, input logic u);
    exp_t e;
    e.who   = 1'b1;
    e.eq    = 1'b0;
    e.taken = 1'b0;
    e.ill   = 1'b0;
    e.lt    = u ? (a < b) : ($signed(a) < $signed(b));
    return e;
  endfunction

  task automatic pop_chk(input logic who);
    exp_t f;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 32'(1), 32'(0));
      return;
    end
    f = sbq.pop_front();
    chk("rsp_owner", 32'(who), 32'(f.who));
    if (who == 1'b0) begin
      chk("sb_r0_taken",   32'(bus.r0_taken),   32'(f.taken));
      chk("sb_r0_eq",      32'(bus.r0_eq),      32'(f.eq));
      chk("sb_r0_lt",      32'(bus.r0_lt),      32'(f.lt));
      chk("sb_r0_illegal", 32'(bus.r0_illegal), 32'(f.ill));
    end else begin
      chk("sb_r1_lt", 32'(bus.r1_lt), 32'(f.lt));
    end
  endtask

  // Samples the pre-edge window: accepts push expectations, drained responses pop them.
  task automatic tick();
    #1;
    acc0 = bus.r0_valid & bus.r0_ready;
    acc1 = bus.r1_valid & bus.r1_ready;
    chk("ready_onehot", 32'(bus.r0_ready & bus.r1_ready), 32'(0));
    chk("rspv_onehot",  32'(bus.r0_rsp_valid & bus.r1_rsp_valid), 32'(0));
    if (acc0) sbq.push_back(model_r0(bus.r0_op1, bus.r0_op2, bus.r0_funct3));
    if (acc1) sbq.push_back(model_r1(bus.r1_op1, bus.r1_op2, bus.r1_unsigned));
    if (bus.r0_rsp_valid && bus.r0_rsp_ready) pop_chk(1'b0);
    if (bus.r1_rsp_valid && bus.r1_rsp_ready) pop_chk(1'b1);
    @(negedge clk);
  endtask

  task automatic send_r0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    bus.r0_valid  = 1'b1;
    bus.r0_op1    = a;
    bus.r0_op2    = b;
    bus.r0_funct3 = f3;
    tick();
    chk("r0_accept", 32'(acc0), 32'(1));
    bus.r0_valid = 1'b0;
    chk("r0_latency", 32'(bus.r0_rsp_valid), 32'(1));
  endtask

  task automatic send_r1(input logic [31:0] a, input logic [31:0] b, input logic u);
    bus.r1_valid    = 1'b1;
    bus.r1_op1      = a;
    bus.r1_op2      = b;
    bus.r1_unsigned = u;
    tick();
    chk("r1_accept", 32'(acc1), 32'(1));
    bus.r1_valid = 1'b0;
    chk("r1_latency", 32'(bus.r1_rsp_valid), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sbq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    bus.r0_valid = 1'b0; bus.r0_op1 = '0; bus.r0_op2 = '0; bus.r0_funct3 = '0; bus.r0_rsp_ready = 1'b1;
    bus.r1_valid = 1'b0; bus.r1_op1 = '0; bus.r1_op2 = '0; bus.r1_unsigned = 1'b0; bus.r1_rsp_ready = 1'b1;
    #1;
    chk("rst_r0_rsp_valid", 32'(bus.r0_rsp_valid), 32'(0));
    chk("rst_r1_rsp_valid", 32'(bus.r1_rsp_valid), 32'(0));
    chk("rst_results", 32'({bus.r0_taken, bus.r0_eq, bus.r0_lt, bus.r0_illegal, bus.r1_lt}), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Branch decode cases.
    send_r0(32'hFFFF_FFFF, 32'h0000_0001, F3_BLT);
    chk("blt_lt", 32'(bus.r0_lt), 32'(1));
    chk("blt_taken", 32'(bus.r0_taken), 32'(1));
    send_r0(32'hFFFF_FFFF, 32'h0000_0001, F3_BLTU);
    chk("bltu_lt", 32'(bus.r0_lt), 32'(0));
    chk("bltu_taken", 32'(bus.r0_taken), 32'(0));
    send_r0(32'h1234_5678, 32'h1234_5678, F3_BNE);
    chk("bne_eq", 32'(bus.r0_eq), 32'(1));
    chk("bne_taken", 32'(bus.r0_taken), 32'(0));
    send_r0(32'h1234_5678, 32'h1234_5678, 3'b010);
    chk("f3_010_illegal", 32'(bus.r0_illegal), 32'(1));
    chk("f3_010_taken", 32'(bus.r0_taken), 32'(0));
    tick();
    chk("drained_idle", 32'(bus.r0_rsp_valid), 32'(0));

    // Both valid from reset with rsp_ready high: strict alternation, no bubbles.
    do_reset();
    bus.r0_valid = 1'b1;
    bus.r1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.r0_op1      = $urandom;
      bus.r0_op2      = (i % 3 == 0) ? bus.r0_op1 : $urandom;
      bus.r0_funct3   = 3'($urandom_range(7, 0));
      bus.r1_op1      = $urandom;
      bus.r1_op2      = $urandom;
      bus.r1_unsigned = 1'($urandom_range(1, 0));
      tick();
      chk("alt_r0_grant", 32'(acc0), 32'(i % 2 == 0));
      chk("alt_r1_grant", 32'(acc1), 32'(i % 2 == 1));
      chk("alt_no_bubble", 32'(bus.r0_rsp_valid | bus.r1_rsp_valid), 32'(1));
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    tick();

    // SLT/SLTU sign boundary, then backpressure on the SLT response.
    send_r1(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    chk("sltu_lt", 32'(bus.r1_lt), 32'(0));
    send_r1(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    chk("slt_lt", 32'(bus.r1_lt), 32'(1));
    bus.r1_rsp_ready = 1'b0;
    bus.r0_valid     = 1'b1;
    bus.r0_op1       = 32'h0000_0005;
    bus.r0_op2       = 32'h0000_0005;
    bus.r0_funct3    = F3_BEQ;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_r0_blocked", 32'(acc0), 32'(0));
      chk("bp_rsp_held", 32'(bus.r1_rsp_valid), 32'(1));
      chk("bp_lt_stable", 32'(bus.r1_lt), 32'(1));
    end
    bus.r1_rsp_ready = 1'b1;
    tick();
    chk("bp_r0_accept_on_drain", 32'(acc0), 32'(1));
    bus.r0_valid = 1'b0;
    chk("bp_r0_rsp", 32'(bus.r0_rsp_valid), 32'(1));
    chk("bp_r1_rsp_gone", 32'(bus.r1_rsp_valid), 32'(0));
    chk("bp_beq_taken", 32'(bus.r0_taken), 32'(1));
    tick();

    // Reset with a pending r0 response; last grant was r0, reset must favour r0 again.
    bus.r0_rsp_ready = 1'b0;
    send_r0(32'h0000_0001, 32'h0000_0002, F3_BGE);
    rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", 32'(bus.r0_rsp_valid), 32'(0));
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.r0_rsp_ready = 1'b1;
    bus.r0_valid = 1'b1;
    bus.r1_valid = 1'b1;
    tick();
    chk("post_rst_r0_wins", 32'(acc0), 32'(1));
    chk("post_rst_r1_waits", 32'(acc1), 32'(0));
    bus.r0_valid = 1'b0;
    tick();
    bus.r1_valid = 1'b0;
    tick();

    // Perf scenario: 5 r0 accepts, 3 r1 accepts, 2 stalled cycles.
    do_reset();
    for (int i = 0; i < 5; i++) send_r0(32'(i), 32'(4 - i), F3_BLT);
    send_r1(32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
    send_r1(32'h0000_0003, 32'hFFFF_FFFF, 1'b1);
    send_r1(32'h0000_0000, 32'h0000_0000, 1'b0);
    bus.r1_rsp_ready = 1'b0;
    bus.r1_valid = 1'b1;
    tick();
    chk("stall_a", 32'(acc1), 32'(0));
    tick();
    chk("stall_b", 32'(acc1), 32'(0));
    bus.r1_valid = 1'b0;
    bus.r1_rsp_ready = 1'b1;
    tick();
`ifdef BCMP_SCHED_PERF_EN
    chk("perf_r0", perf_r0_cnt, 32'd5);
    chk("perf_r1", perf_r1_cnt, 32'd3);
    chk("perf_stall", perf_stall_cnt, 32'd2);
`endif
    chk("sb_empty_at_end", 32'(sbq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
